// File: rtl/id_ex_stage.sv
// Decode/issue stage with integrated ID/EX register: operand and destination
// formation, load-use and multiply-busy stalls, and branch-flush squashing.
module id_ex_stage #(
   parameter int SIZE     = 32,
   parameter int REGBITS  = 5,
   parameter int LINK_REG = 31,
   parameter int CTRLW    = 8,
   parameter int MUL_LAT  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               valid_in,
   input  logic               flush,
   input  logic [31:0]        instruction_in,
   input  logic [SIZE-1:0]    nextPC_in,
   input  logic [SIZE-1:0]    busA_in,
   input  logic [SIZE-1:0]    busB_in,
   input  logic               RType_in,
   input  logic               RegWrite_in,
   input  logic               MemToReg_in,
   input  logic               MemWrite_in,
   input  logic               mul_in,
   input  logic               extOp_in,
   input  logic               LHIOp_in,
   input  logic               PCtoReg_in,
   input  logic [CTRLW-1:0]   ctrl_pass_in,
   output logic               stall_out,
   output logic               valid_out,
   output logic [SIZE-1:0]    nextPC_out,
   output logic [SIZE-1:0]    busA_out,
   output logic [SIZE-1:0]    busB_out,
   output logic [SIZE-1:0]    memVal_out,
   output logic [25:0]        imm26_out,
   output logic [REGBITS-1:0] destReg_out,
   output logic               RegWrite_out,
   output logic               MemToReg_out,
   output logic               MemWrite_out,
   output logic               mul_out,
   output logic [CTRLW-1:0]   ctrl_pass_out
);

   localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [MCW-1:0] MCNT_LOAD = MCW'(MUL_LAT - 1);

   typedef enum logic {RUN, MUL_WAIT} state_t;

   function automatic logic signed [SIZE-1:0] ext_imm(input logic [15:0] imm, input logic sgn);
      ext_imm = sgn ? {{(SIZE-16){imm[15]}}, imm} : {{(SIZE-16){1'b0}}, imm};
   endfunction

   // ISA numbers bit 0 as the MSB: rs=[6:10], rt=[11:15], rd=[16:20], imm16=[16:31]
   logic [4:0]  rs_f, rt_f, rd_f;
   logic [15:0] imm16;
   logic        unused_opcode;
   assign rs_f          = instruction_in[25:21];
   assign rt_f          = instruction_in[20:16];
   assign rd_f          = instruction_in[15:11];
   assign imm16         = instruction_in[15:0];
   assign unused_opcode = ^instruction_in[31:26];

   state_t                   state_q, state_d;
   logic [MCW-1:0]           mcnt_q, mcnt_d;
   logic                     valid_q, regwrite_q, memtoreg_q, memwrite_q, mul_q;
   logic [REGBITS-1:0]       dest_q, dest_d;
   logic [SIZE-1:0]          a_q, a_d, b_q, b_d, mem_q, pc_q;
   logic signed [SIZE-1:0]   imm_ext;
   logic [25:0]              imm26_q;
   logic [CTRLW-1:0]         ctrl_q;
   logic                     rt_used, lu, busy, issue;

   always_comb begin
      imm_ext = ext_imm(imm16, extOp_in);
      a_d     = LHIOp_in ? {{(SIZE-16){1'b0}}, imm16} : busA_in;
      b_d     = RType_in ? busB_in : (LHIOp_in ? SIZE'(16) : imm_ext);
      dest_d  = PCtoReg_in ? REGBITS'(LINK_REG) : (RType_in ? REGBITS'(rd_f) : REGBITS'(rt_f));
   end

   // Hazard detection against the instruction now sitting in EX
   assign rt_used   = RType_in | MemWrite_in;
   assign lu        = valid_q & memtoreg_q & regwrite_q & (dest_q != '0) &
                      ((dest_q == REGBITS'(rs_f)) | (rt_used & (dest_q == REGBITS'(rt_f))));
   assign busy      = (state_q == MUL_WAIT);
   assign stall_out = valid_in & (lu | busy) & ~flush;
   assign issue     = valid_in & ~flush & ~lu & ~busy;

   always_comb begin
      state_d = state_q;
      mcnt_d  = mcnt_q;
      case (state_q)
         RUN: begin
            if (issue && mul_in && (MUL_LAT > 1)) begin
               state_d = MUL_WAIT;
               mcnt_d  = MCNT_LOAD;
            end
         end
         MUL_WAIT: begin
            if (flush || (mcnt_q <= MCW'(1))) begin
               state_d = RUN;
               mcnt_d  = '0;
            end else begin
               mcnt_d  = mcnt_q - MCW'(1);
            end
         end
         default: begin
            state_d = RUN;
            mcnt_d  = '0;
         end
      endcase
   end

   // ID -> EX register boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         mcnt_q     <= '0;
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memwrite_q <= 1'b0;
         mul_q      <= 1'b0;
         dest_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         mem_q      <= '0;
         pc_q       <= '0;
         imm26_q    <= '0;
         ctrl_q     <= '0;
      end else begin
         state_q    <= state_d;
         mcnt_q     <= mcnt_d;
         valid_q    <= issue;
         regwrite_q <= issue & RegWrite_in;
         memtoreg_q <= issue & MemToReg_in;
         memwrite_q <= issue & MemWrite_in;
         mul_q      <= issue & mul_in;
         if (issue) begin
            dest_q  <= dest_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mem_q   <= busB_in;
            pc_q    <= nextPC_in;
            imm26_q <= instruction_in[25:0];
            ctrl_q  <= ctrl_pass_in;
         end
      end
   end

   assign valid_out     = valid_q;
   assign RegWrite_out  = regwrite_q;
   assign MemToReg_out  = memtoreg_q;
   assign MemWrite_out  = memwrite_q;
   assign mul_out       = mul_q;
   assign destReg_out   = dest_q;
   assign busA_out      = a_q;
   assign busB_out      = b_q;
   assign memVal_out    = mem_q;
   assign nextPC_out    = pc_q;
   assign imm26_out     = imm26_q;
   assign ctrl_pass_out = ctrl_q;

endmodule
